// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one SRAM read per cycle and buffers
// returned words in a small queue so decode stalls never lose a fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h1c00_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allow_in,
  input  logic        br_taken_cancel,
  input  logic [31:0] br_target,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst
);

  localparam int               PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [2:0]       DEPTH_L  = 3'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             req_inflight_q, req_inflight_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [1:0]       count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      buf_pc_q   [BUF_DEPTH];
  logic [31:0]      buf_pc_d   [BUF_DEPTH];
  logic [31:0]      buf_inst_q [BUF_DEPTH];
  logic [31:0]      buf_inst_d [BUF_DEPTH];

  logic             has_buf_s;
  logic             valid_s;
  logic             pop_s;
  logic             pop_buf_s;
  logic             push_s;
  logic [2:0]       occ_s;
  logic             en_s;
  logic [31:0]      head_pc_s;
  logic [31:0]      head_inst_s;

  // Head selection, handshake, credit check and next-state computation.
  always_comb begin
    fetch_pc_d     = fetch_pc_q;
    req_inflight_d = req_inflight_q;
    req_pc_d       = req_pc_q;
    count_d        = count_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    buf_pc_d       = buf_pc_q;
    buf_inst_d     = buf_inst_q;

    has_buf_s = (count_q != 2'd0);
    if (has_buf_s) begin
      head_pc_s   = buf_pc_q[rd_ptr_q];
      head_inst_s = buf_inst_q[rd_ptr_q];
    end else begin
      head_pc_s   = req_pc_q;
      head_inst_s = inst_sram_rdata;
    end

    valid_s   = reset & (has_buf_s | req_inflight_q) & ~br_taken_cancel;
    pop_s     = valid_s & ds_allow_in;
    pop_buf_s = pop_s & has_buf_s;
    // A response consumed through the bypass path never enters the queue.
    push_s    = req_inflight_q & ~(pop_s & ~has_buf_s) & ~br_taken_cancel;
    occ_s     = {1'b0, count_q} + {2'b00, req_inflight_q} - {2'b00, pop_s};
    en_s      = reset & (br_taken_cancel | (occ_s < DEPTH_L));

    if (br_taken_cancel) begin
      count_d        = 2'd0;
      rd_ptr_d       = '0;
      wr_ptr_d       = '0;
      req_inflight_d = 1'b1;
      req_pc_d       = br_target;
      fetch_pc_d     = br_target + 32'd4;
    end else begin
      if (push_s) begin
        buf_pc_d[wr_ptr_q]   = req_pc_q;
        buf_inst_d[wr_ptr_q] = inst_sram_rdata;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_buf_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_s} - {1'b0, pop_buf_s};
      if (en_s) begin
        req_inflight_d = 1'b1;
        req_pc_d       = fetch_pc_q;
        fetch_pc_d     = fetch_pc_q + 32'd4;
      end else begin
        req_inflight_d = 1'b0;
      end
    end
  end

  // State registers; asynchronous clear discards any response still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q     <= RESET_PC;
      req_inflight_q <= 1'b0;
      req_pc_q       <= 32'd0;
      count_q        <= 2'd0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_q[i]   <= 32'd0;
        buf_inst_q[i] <= 32'd0;
      end
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      req_inflight_q <= req_inflight_d;
      req_pc_q       <= req_pc_d;
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      buf_pc_q       <= buf_pc_d;
      buf_inst_q     <= buf_inst_d;
    end
  end

  assign inst_sram_en    = en_s;
  assign inst_sram_we    = 4'b0000;
  assign inst_sram_addr  = br_taken_cancel ? br_target : fetch_pc_q;
  assign inst_sram_wdata = 32'd0;
  assign to_ds_valid     = valid_s;
  assign fs_pc           = valid_s ? head_pc_s : 32'd0;
  assign fs_inst         = valid_s ? head_inst_s : 32'd0;

  if_stage_chk #(.BUF_DEPTH(BUF_DEPTH)) u_chk (
    .clk    (clk),
    .rst_n  (reset),
    .count_i(count_q)
  );

endmodule

// Queue occupancy checker: the credit rule must keep count within the queue depth.
module if_stage_chk #(
  parameter int BUF_DEPTH = 2
) (
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] count_i
);

  // Flag any occupancy beyond the physical queue size.
  always @(posedge clk) begin
    if (rst_n) begin
      assert ({30'd0, count_i} <= 32'(BUF_DEPTH))
        else $error("if_stage queue overflow: count=%0d", count_i);
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed plus randomized bench for if_stage; the reference tracks the next pc owed
// to decode and how many fetches are outstanding ahead of it.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allow_in;
  logic        br_taken_cancel;
  logic [31:0] br_target;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  int          ahead;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .ds_allow_in    (ds_allow_in),
    .br_taken_cancel(br_taken_cancel),
    .br_target      (br_target),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .to_ds_valid    (to_ds_valid),
    .fs_pc          (fs_pc),
    .fs_inst        (fs_inst)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Synchronous SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic do_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      reset           = 1'b0;
      ds_allow_in     = 1'b1;
      br_taken_cancel = 1'b0;
      #1;
      chk("rst_en",    {31'd0, inst_sram_en}, 32'd0);
      chk("rst_valid", {31'd0, to_ds_valid},  32'd0);
      chk("rst_fs_pc", fs_pc,   32'd0);
      chk("rst_fs_inst", fs_inst, 32'd0);
    end
    exp_pc = RESET_PC;
    ahead  = 0;
  endtask

  task automatic step(input logic allow, input logic cancel, input logic [31:0] tgt);
    logic        exp_valid;
    logic        exp_en;
    logic        pop;
    logic [31:0] exp_addr;
    @(negedge clk);
    reset           = 1'b1;
    ds_allow_in     = allow;
    br_taken_cancel = cancel;
    br_target       = tgt;
    #1;
    exp_valid = (ahead > 0) && !cancel;
    pop       = exp_valid && allow;
    exp_en    = cancel || ((ahead - (pop ? 1 : 0)) < 2);
    exp_addr  = cancel ? tgt : exp_pc + 32'(4 * ahead);
    chk("to_ds_valid", {31'd0, to_ds_valid}, {31'd0, exp_valid});
    chk("fs_pc",   fs_pc,   exp_valid ? exp_pc : 32'd0);
    chk("fs_inst", fs_inst, exp_valid ? mem_word(exp_pc) : 32'd0);
    chk("inst_sram_en", {31'd0, inst_sram_en}, {31'd0, exp_en});
    if (exp_en) chk("inst_sram_addr", inst_sram_addr, exp_addr);
    if (cancel) begin
      exp_pc = tgt;
      ahead  = 1;
    end else begin
      if (pop) exp_pc = exp_pc + 32'd4;
      ahead = ahead - (pop ? 1 : 0) + (exp_en ? 1 : 0);
    end
  endtask

  initial begin
    reset           = 1'b0;
    ds_allow_in     = 1'b0;
    br_taken_cancel = 1'b0;
    br_target       = 32'd0;
    exp_pc          = RESET_PC;
    ahead           = 0;

    do_reset(2);
    chk("tie_we",    {28'd0, inst_sram_we}, 32'd0);
    chk("tie_wdata", inst_sram_wdata, 32'd0);

    // Streaming after reset release.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'd0);

    // Decode stall then resume.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0);
    chk("stall_en", {31'd0, inst_sram_en}, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0);

    // Redirect while queue holds stalled entries.
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h1c00_0100);
    chk("redir_addr", inst_sram_addr, 32'h1c00_0100);
    step(1'b1, 1'b0, 32'd0);
    chk("redir_first", fs_pc, 32'h1c00_0100);
    step(1'b1, 1'b0, 32'd0);
    chk("redir_second", fs_pc, 32'h1c00_0104);

    // Back-to-back redirects: only the last target survives.
    step(1'b1, 1'b1, 32'h1c00_0200);
    step(1'b1, 1'b1, 32'h1c00_0300);
    step(1'b1, 1'b0, 32'd0);
    chk("double_redir", fs_pc, 32'h1c00_0300);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0);

    // Reset in the middle of a stall.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);
    do_reset(1);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    chk("post_reset_pc", fs_pc, RESET_PC);

    // Sequential address wrap past the top of memory.
    step(1'b1, 1'b1, 32'hffff_fff8);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    chk("wrap_addr", inst_sram_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0);

    // Randomized traffic including unaligned targets and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
